// File: rtl/ap_pkg.sv
// Shared AP host definitions: op codes, default geometry,
// controller state encoding and the readback beat layout.
package ap_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 1024;

  localparam logic [2:0] OP_OR  = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_A = 3'd1,
    S_WR_B = 3'd2,
    S_ARM  = 3'd3,
    S_RUN  = 3'd4,
    S_RD   = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

endpackage

// File: rtl/ap_out_skid.sv
// One-entry valid/ready output register for the readback stream.
// Accepts a new beat whenever empty or draining in the same cycle.
module ap_out_skid
  import ap_pkg::*;
#(
  parameter int W = $bits(beat_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         vld;
  logic [W-1:0] dat;

  assign in_ready  = !vld || out_ready;
  assign out_valid = vld;
  assign out_data  = dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (in_ready) begin
      vld <= in_valid;
      if (in_valid) dat <= in_data;
    end
  end

endmodule

// File: rtl/ap_host_ctrl.sv
// Host-side sequencer for the associative processor: loads operand
// rows, arms and runs a command, then streams one column back.
module ap_host_ctrl
  import ap_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [2:0]        job_op,
  input  logic [ADDR_W:0]   job_len,
  input  logic              job_rd_col,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              ap_rst,
  output logic              ap_mode,
  output logic [2:0]        ap_cmd,
  output logic              ap_write_en,
  output logic              ap_sel_col,
  output logic [7:0]        ap_data,
  output logic [ADDR_W-1:0] ap_addr,
  input  logic [7:0]        ap_data_out,
  input  logic              ap_irq,
  output logic              busy,
  output logic              err_timeout
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [TW-1:0]   TMAX    = TW'(TIMEOUT - 1);

  state_t          state, nxt;
  logic [2:0]      op;
  logic [ADDR_W:0] len, row_cnt, len_eff;
  logic            rd_col;
  logic [7:0]      b_hold;
  logic [TW-1:0]   timer;
  logic            err;
  logic            last_row, push, sk_ready, sk_valid;
  beat_t           beat_in, beat_out;

  assign len_eff  = (job_len == '0 || job_len > DEPTH_L)
                  ? DEPTH_L : job_len;
  assign last_row = row_cnt == len - 1'b1;
  assign push     = state == S_RD && row_cnt < len && sk_ready;
  assign beat_in  = '{last: last_row, data: ap_data_out};

  ap_out_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_ready  (sk_ready),
    .in_data   (beat_in),
    .out_valid (sk_valid),
    .out_ready (out_ready),
    .out_data  (beat_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op      <= '0;
      len     <= '0;
      rd_col  <= 1'b0;
      row_cnt <= '0;
      b_hold  <= '0;
      timer   <= '0;
      err     <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: if (job_valid) begin
          op      <= job_op;
          len     <= len_eff;
          rd_col  <= job_rd_col;
          row_cnt <= '0;
          err     <= 1'b0;
        end
        S_WR_A: if (in_valid) b_hold <= in_data[15:8];
        S_WR_B: row_cnt <= row_cnt + 1'b1;
        S_ARM:  timer <= '0;
        S_RUN: begin
          timer <= timer + 1'b1;
          if (ap_irq) row_cnt <= '0;
          else if (timer == TMAX) err <= 1'b1;
        end
        S_RD: if (push) row_cnt <= row_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (job_valid) nxt = S_WR_A;
      S_WR_A: if (in_valid) nxt = S_WR_B;
      S_WR_B: nxt = last_row ? S_ARM : S_WR_A;
      S_ARM:  nxt = S_RUN;
      S_RUN: begin
        if (ap_irq) nxt = S_RD;
        else if (timer == TMAX) nxt = S_ERR;
      end
      S_RD: if (sk_valid && out_ready && beat_out.last) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      S_ERR:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Everything except ap_rst is forced quiet while rst is high.
  always_comb begin
    in_ready    = 1'b0;
    ap_write_en = 1'b0;
    ap_sel_col  = 1'b0;
    ap_addr     = '0;
    ap_data     = '0;
    ap_mode     = 1'b0;
    ap_cmd      = '0;
    if (!rst) begin
      unique case (state)
        S_WR_A: begin
          in_ready    = 1'b1;
          ap_write_en = in_valid;
          ap_addr     = row_cnt[ADDR_W-1:0];
          ap_data     = in_data[7:0];
        end
        S_WR_B: begin
          ap_write_en = 1'b1;
          ap_sel_col  = 1'b1;
          ap_addr     = row_cnt[ADDR_W-1:0];
          ap_data     = b_hold;
        end
        S_ARM: ap_cmd = op;
        S_RUN: begin
          ap_mode = 1'b1;
          ap_cmd  = op;
        end
        S_RD: begin
          ap_sel_col = rd_col;
          ap_addr    = row_cnt[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign ap_rst      = rst || state == S_ARM || state == S_ERR;
  assign job_ready   = !rst && state == S_IDLE;
  assign busy        = !rst && state != S_IDLE;
  assign err_timeout = err;
  assign out_valid   = !rst && sk_valid;
  assign out_data    = beat_out.data;
  assign out_last    = out_valid && beat_out.last;

endmodule

// File: tb/tb_ap_host_ctrl.sv
// Directed bench for ap_host_ctrl with a small AP memory model.
// Small geometry: 8 rows, 16-cycle completion timeout.
module tb_ap_host_ctrl;

  localparam int AW = 3;
  localparam int DP = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [2:0]    job_op = '0;
  logic [AW:0]   job_len = '0;
  logic          job_rd_col = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          out_last;
  logic          ap_rst, ap_mode, ap_write_en, ap_sel_col;
  logic [2:0]    ap_cmd;
  logic [7:0]    ap_data, ap_data_out;
  logic [AW-1:0] ap_addr;
  logic          ap_irq;
  logic          busy, err_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem [2][DP];
  int         mode_cnt = 0;
  logic       irq_en = 1'b1;
  logic       irq_force = 1'b0;

  always #5 clk = ~clk;

  ap_host_ctrl #(.ADDR_W(AW), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_op(job_op), .job_len(job_len), .job_rd_col(job_rd_col),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .ap_rst(ap_rst), .ap_mode(ap_mode), .ap_cmd(ap_cmd),
    .ap_write_en(ap_write_en), .ap_sel_col(ap_sel_col),
    .ap_data(ap_data), .ap_addr(ap_addr),
    .ap_data_out(ap_data_out), .ap_irq(ap_irq),
    .busy(busy), .err_timeout(err_timeout)
  );

  // AP model: two-column memory, completes 4 cycles into RUN.
  always @(posedge clk) begin
    if (ap_write_en) mem[ap_sel_col][ap_addr] <= ap_data;
    mode_cnt <= ap_mode ? mode_cnt + 1 : 0;
  end
  assign ap_data_out = mem[ap_sel_col][ap_addr];
  assign ap_irq = irq_force || (irq_en && ap_mode && mode_cnt == 3);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] pairs [4] = '{16'h0FF0, 16'h0102, 16'h0000, 16'hFF00};
  logic [7:0]  exp_a [4] = '{8'hF0, 8'h02, 8'h00, 8'h00};
  logic        pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int   beats, cyc, wr, first_c, last_c;
    logic stalled;
    logic [7:0] held;
    logic [AW-1:0] max_addr;

    tick(); tick();
    chk("rst_job_ready", job_ready, 0);
    chk("rst_ap_rst", ap_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", ap_write_en, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;
    tick();
    chk("idle_job_ready", job_ready, 1);
    chk("idle_ap_rst", ap_rst, 0);
    chk("idle_busy", busy, 0);

    irq_force = 1'b1;
    tick();
    irq_force = 1'b0;
    #1;
    chk("irq_ignored_idle", job_ready, 1);

    // Job 1: OR, 4 rows, read column A, one input gap before row 1.
    job_valid = 1'b1; job_op = 3'd0; job_len = 4'd4; job_rd_col = 1'b0;
    tick();
    job_valid = 1'b0;
    #1;
    chk("wa_busy", busy, 1);
    chk("wa_in_ready", in_ready, 1);
    chk("wa_idle_wr_en", ap_write_en, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        in_valid = 1'b0;
        #1;
        chk("gap_wr_en", ap_write_en, 0);
        chk("gap_addr", ap_addr, 1);
        tick();
        chk("gap_in_ready", in_ready, 1);
      end
      in_valid = 1'b1;
      in_data  = pairs[i];
      #1;
      chk("wa_wr_en", ap_write_en, 1);
      chk("wa_sel", ap_sel_col, 0);
      chk("wa_addr", ap_addr, i);
      chk("wa_data", ap_data, exp_a[i]);
      chk("wa_mode", ap_mode, 0);
      tick();
      chk("wb_in_ready", in_ready, 0);
      chk("wb_wr_en", ap_write_en, 1);
      chk("wb_sel", ap_sel_col, 1);
      chk("wb_addr", ap_addr, i);
      chk("wb_data", ap_data, pairs[i][15:8]);
      in_valid = 1'b0;
      tick();
    end
    chk("arm_ap_rst", ap_rst, 1);
    chk("arm_mode", ap_mode, 0);
    chk("arm_cmd", ap_cmd, 0);
    tick();
    chk("run_ap_rst", ap_rst, 0);
    chk("run_mode", ap_mode, 1);
    for (int k = 0; k < 50 && ap_mode; k++) tick();
    chk("run_irq_exit", ap_mode, 0);

    beats = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 40; c++) begin
      if (beats == 4) break;
      out_ready = pat[c % 4];
      #1;
      if (out_valid) begin
        if (stalled) chk("stall_stable", out_data, held);
        if (out_ready) begin
          chk("rd_data", out_data, exp_a[beats]);
          chk("rd_last", out_last, beats == 3);
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end
      tick();
    end
    chk("rd_beats", beats, 4);
    out_ready = 1'b0;
    #1;
    chk("done_out_valid", out_valid, 0);
    chk("done_busy", busy, 1);
    tick();
    chk("post_done_busy", busy, 0);
    chk("post_done_ready", job_ready, 1);

    // Job 2: XOR, no completion, expect timeout.
    irq_en = 1'b0;
    job_valid = 1'b1; job_op = 3'd2; job_len = 4'd1; job_rd_col = 1'b1;
    tick();
    job_valid = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234;
    tick();
    in_valid = 1'b0;
    tick();
    chk("to_arm_cmd", ap_cmd, 2);
    chk("to_arm_rst", ap_rst, 1);
    tick();
    cyc = 0;
    for (int k = 0; k < 40 && ap_mode; k++) begin
      cyc++;
      tick();
    end
    chk("to_run_cycles", cyc, 16);
    chk("to_err", err_timeout, 1);
    chk("to_err_mode", ap_mode, 0);
    chk("to_err_ap_rst", ap_rst, 1);
    tick();
    chk("to_idle_busy", busy, 0);
    chk("to_err_sticky", err_timeout, 1);
    chk("to_idle_ready", job_ready, 1);

    // Job 3: len 0 means full depth; read column B at full rate.
    irq_en = 1'b1;
    job_valid = 1'b1; job_op = 3'd1; job_len = 4'd0; job_rd_col = 1'b1;
    tick();
    job_valid = 1'b0;
    #1;
    chk("j3_err_clear", err_timeout, 0);
    wr = 0; max_addr = '0;
    begin
      int r;
      r = 0;
      in_valid = 1'b1;
      for (int c = 0; c < 40 && !ap_rst; c++) begin
        in_data = {8'h10 + 8'(r), 8'h20 + 8'(r)};
        #1;
        if (ap_write_en) wr++;
        if (ap_write_en && ap_sel_col) begin
          max_addr = ap_addr;
          r++;
        end
        tick();
      end
    end
    in_valid = 1'b0;
    chk("j3_write_cycles", wr, 16);
    chk("j3_last_addr", max_addr, 7);
    chk("j3_arm", ap_rst, 1);
    tick();
    for (int k = 0; k < 50 && ap_mode; k++) tick();
    chk("j3_irq_exit", ap_mode, 0);
    beats = 0; first_c = -1; last_c = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (beats == 8) break;
      #1;
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        chk("j3_data", out_data, 8'h10 + 8'(beats));
        chk("j3_last", out_last, beats == 7);
        beats++;
      end
      tick();
    end
    chk("j3_beats", beats, 8);
    chk("j3_throughput", last_c - first_c, 7);
    tick();
    chk("j3_idle", busy, 0);

    // Job 4: reset during WR_B abandons the job.
    out_ready = 1'b0;
    job_valid = 1'b1; job_op = 3'd0; job_len = 4'd3; job_rd_col = 1'b0;
    tick();
    job_valid = 1'b0;
    in_valid = 1'b1; in_data = 16'hABCD;
    tick();
    in_valid = 1'b0;
    chk("j4_in_wr_b", ap_sel_col, 1);
    rst = 1'b1;
    #1;
    chk("j4_rst_ap_rst", ap_rst, 1);
    chk("j4_rst_wr_en", ap_write_en, 0);
    chk("j4_rst_job_ready", job_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("j4_wr_en", ap_write_en, 0);
    chk("j4_addr", ap_addr, 0);
    chk("j4_data", ap_data, 0);
    chk("j4_sel", ap_sel_col, 0);
    chk("j4_cmd", ap_cmd, 0);
    chk("j4_busy", busy, 0);
    chk("j4_job_ready", job_ready, 1);
    out_ready = 1'b1;
    cyc = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) cyc++;
      tick();
    end
    chk("j4_no_beats", cyc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ap_host_ctrl.md
AP_HOST_CTRL -- requirements
Module: ap_host_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, AP word-address width; DEPTH, default 1024, AP rows; TIMEOUT, default 8192, max cycles to wait for AP completion.
REQ-002 SHALL have ports: clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: job_valid  in  1 / job_ready  out  1 / job_op  in  3 (AP command) / job_len  in  ADDR_W+1 (rows, 1..DEPTH) / job_rd_col  in  1 (readback column: 0=A, 1=B).
REQ-005 SHALL have ports: in_valid  in  1 / in_ready  out  1 / in_data  in  16 ({b[7:0], a[7:0]} operand pair).
REQ-006 SHALL have ports: out_valid  out  1 / out_ready  in  1 / out_data  out  8 / out_last  out  1 (readback stream).
REQ-007 SHALL have AP-side ports: ap_rst  out  1, ap_mode  out  1, ap_cmd  out  3, ap_write_en  out  1, ap_sel_col  out  1, ap_data  out  8, ap_addr  out  ADDR_W, ap_data_out  in  8, ap_irq  in  1.
REQ-008 SHALL have status ports: busy  out  1; err_timeout  out  1 (sticky until next accepted job).

Function
REQ-009 SHALL implement FSM states IDLE, WR_A, WR_B, ARM, RUN, RD, DONE, ERR.
REQ-010 IDLE: job_ready=1; on job_valid, latch op/len/rd_col, row_cnt=0, clear err_timeout, go WR_A.
REQ-011 job_len=0 or >DEPTH SHALL be treated as DEPTH.
REQ-012 WR_A: in_ready=1; on in_valid, drive ap_write_en=1, ap_sel_col=0, ap_addr=row_cnt, ap_data=in_data[7:0]; hold in_data[15:8] in a register; go WR_B. Without in_valid, ap_write_en=0, remain.
REQ-013 WR_B: in_ready=0; drive ap_write_en=1, ap_sel_col=1, same ap_addr, ap_data=held b; increment row_cnt; go ARM if row_cnt==len-1, else WR_A.
REQ-014 ap_mode SHALL be 0 whenever ap_write_en=1; loading costs exactly 2 cycles per row with continuous in_valid.
REQ-015 ARM: ap_rst=1 for exactly one cycle, ap_mode=0, ap_cmd=op; go RUN; timer=0.
REQ-016 RUN: ap_mode=1, ap_cmd held; timer increments each cycle; on ap_irq=1 deassert ap_mode next cycle, row_cnt=0, go RD; if timer reaches TIMEOUT-1 without ap_irq, set err_timeout, go ERR.
REQ-017 RD: ap_mode=0, ap_sel_col=rd_col, ap_addr=row_cnt; ap_data_out sampled combinationally the same cycle into out_data register, out_valid=1 next cycle.
REQ-018 Readback SHALL obey valid/ready: out_data/out_last stable while out_valid=1 and out_ready=0; ap_addr advances only when the output register is empty or drains that cycle; throughput 1 row/cycle with out_ready=1.
REQ-019 out_last=1 exactly on row len-1; after that beat is accepted go DONE.
REQ-020 DONE: one cycle, busy=0 next cycle, return IDLE. ERR: ap_mode=0, ap_rst=1 for one cycle, then IDLE with err_timeout held.
REQ-021 busy=1 in every state except IDLE.
REQ-022 ap_irq outside RUN SHALL be ignored.
REQ-023 Rows beyond len are not written; their AP contents are unspecified to the caller.

Reset
REQ-024 On rst: state=IDLE, row_cnt=0, timer=0; outputs job_ready=0 during rst then 1, in_ready=0, out_valid=0, out_last=0, out_data=0, ap_mode=0, ap_write_en=0, ap_rst=1 (asserted while rst), ap_cmd=0, ap_addr=0, ap_data=0, ap_sel_col=0, busy=0, err_timeout=0.
REQ-025 rst mid-job SHALL abandon the job without emitting further out beats.

Structure
REQ-026 A shared package ap_pkg SHALL hold AP op codes (OR=0, AND=1, XOR=2, NOT=3), ADDR_W/DEPTH defaults and the FSM state enum.
REQ-027 The readback output register SHALL be a sub-module ap_out_skid (1-entry valid/ready register, width 9).

Verification
REQ-028 job op=0 len=4, pairs (0x0F,0xF0),(0x01,0x02),(0x00,0x00),(0xFF,0x00) -> 8 write cycles, alternating ap_sel_col 0/1, addresses 0,0,1,1,2,2,3,3.
REQ-029 With AP model: ARM pulses ap_rst 1 cycle, ap_mode high until ap_irq, then 4 readback beats of column A = 0xF0,0x02,0x00,0x00, out_last on beat 4.
REQ-030 out_ready toggled 1,0,0,1 during readback -> no beat lost or duplicated, out_data stable while stalled.
REQ-031 ap_irq never asserted, TIMEOUT=16 -> err_timeout=1 after 16 RUN cycles, ap_mode=0, return IDLE; next job clears err_timeout.
REQ-032 job_len=0 -> DEPTH rows written; rst asserted during WR_B -> all AP outputs at reset values next cycle, no out_valid.
REQ-033 in_valid gaps during load -> ap_write_en low on gap cycles, addresses unchanged.
